// File: rtl/csr_islem_birimi.sv
// csr_islem_birimi
// Execute-stage CSR micro-op unit. It accepts one Zicsr micro-op at a time,
// claims the target CSR while reading its old value, issues the
// read-modify-write back to the CSR unit, and returns the old value for rd.
// Illegal ops raise an illegal-instruction exception instead of touching the CSR.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   uop_*_i / uop_hazir_o     micro-op handshake and fields
//   oku_istek_*_o             CSR read address and claim pulse with tag
//   csr_veri_i/csr_gecerli_i  combinational read data and valid from the CSR unit
//   yaz_istek_*_o             CSR write request (one cycle per op)
//   sonuc_*_o / sonuc_hazir_i result toward writeback
//   odd_*_o                   execute exception port
//   bosalt_i                  pipeline flush

module csr_islem_birimi #(
    parameter int MXLEN         = 32,
    parameter int CSR_ADRES_BIT = 12,
    parameter int UOP_TAG_BIT   = 5,
    parameter int EXC_CODE_BIT  = 4,
    parameter int PS_BIT        = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic                     uop_gecerli_i,
    output logic                     uop_hazir_o,
    input  logic [2:0]               uop_islem_i,
    input  logic [CSR_ADRES_BIT-1:0] uop_adres_i,
    input  logic [4:0]               uop_rs1_i,
    input  logic [MXLEN-1:0]         uop_rs1_veri_i,
    input  logic [4:0]               uop_rd_i,
    input  logic [UOP_TAG_BIT-1:0]   uop_etiket_i,
    input  logic [PS_BIT-1:0]        uop_ps_i,

    output logic [CSR_ADRES_BIT-1:0] oku_istek_adres_o,
    output logic [UOP_TAG_BIT-1:0]   oku_istek_etiket_o,
    output logic                     oku_istek_etiket_gecerli_o,
    input  logic [MXLEN-1:0]         csr_veri_i,
    input  logic                     csr_gecerli_i,

    output logic [MXLEN-1:0]         yaz_istek_veri_o,
    output logic [CSR_ADRES_BIT-1:0] yaz_istek_adres_o,
    output logic [UOP_TAG_BIT-1:0]   yaz_istek_etiket_o,
    output logic                     yaz_istek_gecerli_o,

    output logic [MXLEN-1:0]         sonuc_veri_o,
    output logic [4:0]               sonuc_rd_o,
    output logic                     sonuc_gecerli_o,
    input  logic                     sonuc_hazir_i,

    output logic [PS_BIT-1:0]        odd_ps_o,
    output logic [EXC_CODE_BIT-1:0]  odd_kod_o,
    output logic [MXLEN-1:0]         odd_bilgi_o,
    output logic                     odd_gecerli_o,

    input  logic                     bosalt_i
);

    typedef enum logic [2:0] {
        BOSTA   = 3'd0,
        OKU     = 3'd1,
        YAZ     = 3'd2,
        SONUC   = 3'd3,
        ISTISNA = 3'd4
    } durum_t;

    localparam logic [EXC_CODE_BIT-1:0] KOD_YASADISI = EXC_CODE_BIT'(2);

    durum_t                     durum_q, durum_d;
    logic [1:0]                 islem_q;
    logic [CSR_ADRES_BIT-1:0]   adres_q;
    logic [MXLEN-1:0]           kaynak_q;
    logic                       yok_q;
    logic [4:0]                 rd_q;
    logic [UOP_TAG_BIT-1:0]     etiket_q;
    logic [PS_BIT-1:0]          ps_q;
    logic [MXLEN-1:0]           eski_q;

    logic                       kabul;
    logic                       yok_giris;
    logic                       yasadisi_giris;
    logic [MXLEN-1:0]           kaynak_giris;
    logic                       oku_al;
    logic [MXLEN-1:0]           yaz_veri;

    assign uop_hazir_o = (durum_q == BOSTA) && !bosalt_i && !rst_i;
    assign kabul       = uop_gecerli_i && uop_hazir_o;

    // Only the set/clear forms (funct3 bit 1 set) may skip the write when rs1/uimm
    // is zero; a skipped write is what makes a read-only CSR access legal.
    always_comb begin
        yok_giris      = uop_islem_i[1] && (uop_rs1_i == 5'd0);
        yasadisi_giris = (uop_islem_i[1:0] == 2'b00) ||
                         ((uop_adres_i[CSR_ADRES_BIT-1 -: 2] == 2'b11) && !yok_giris);
        kaynak_giris   = uop_islem_i[2] ? {{(MXLEN-5){1'b0}}, uop_rs1_i} : uop_rs1_veri_i;
    end

    // A flush in OKU wins over a valid read so no claim is left outstanding.
    assign oku_al = (durum_q == OKU) && csr_gecerli_i && !bosalt_i;

    // Next-state logic.
    always_comb begin
        durum_d = durum_q;
        unique case (durum_q)
            BOSTA:   if (kabul) durum_d = yasadisi_giris ? ISTISNA : OKU;
            OKU: begin
                if (bosalt_i)           durum_d = BOSTA;
                else if (csr_gecerli_i) durum_d = YAZ;
            end
            YAZ:     durum_d = bosalt_i ? BOSTA : SONUC;
            SONUC:   if (bosalt_i || sonuc_hazir_i) durum_d = BOSTA;
            ISTISNA: if (bosalt_i) durum_d = BOSTA;
            default: durum_d = BOSTA;
        endcase
    end

    // Read-modify-write data; a suppressed write echoes the old value so the
    // claimed CSR still revalidates.
    always_comb begin
        unique case (islem_q)
            2'b01:   yaz_veri = kaynak_q;
            2'b10:   yaz_veri = eski_q | kaynak_q;
            2'b11:   yaz_veri = eski_q & ~kaynak_q;
            default: yaz_veri = eski_q;
        endcase
        if (yok_q) yaz_veri = eski_q;
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        oku_istek_adres_o          = '0;
        oku_istek_etiket_o         = '0;
        oku_istek_etiket_gecerli_o = 1'b0;
        yaz_istek_veri_o           = '0;
        yaz_istek_adres_o          = '0;
        yaz_istek_etiket_o         = '0;
        yaz_istek_gecerli_o        = 1'b0;
        sonuc_veri_o               = '0;
        sonuc_rd_o                 = '0;
        sonuc_gecerli_o            = 1'b0;
        odd_ps_o                   = '0;
        odd_kod_o                  = '0;
        odd_bilgi_o                = '0;
        odd_gecerli_o              = 1'b0;
        if (!rst_i) begin
            unique case (durum_q)
                OKU: begin
                    oku_istek_adres_o          = adres_q;
                    oku_istek_etiket_o         = etiket_q;
                    oku_istek_etiket_gecerli_o = oku_al;
                end
                YAZ: begin
                    yaz_istek_veri_o    = yaz_veri;
                    yaz_istek_adres_o   = adres_q;
                    yaz_istek_etiket_o  = etiket_q;
                    yaz_istek_gecerli_o = 1'b1;
                end
                SONUC: begin
                    sonuc_veri_o    = eski_q;
                    sonuc_rd_o      = rd_q;
                    sonuc_gecerli_o = 1'b1;
                end
                ISTISNA: begin
                    odd_ps_o      = ps_q;
                    odd_kod_o     = KOD_YASADISI;
                    odd_bilgi_o   = {{(MXLEN-CSR_ADRES_BIT){1'b0}}, adres_q};
                    odd_gecerli_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State, latched op fields and the captured old CSR value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q  <= BOSTA;
            islem_q  <= '0;
            adres_q  <= '0;
            kaynak_q <= '0;
            yok_q    <= 1'b0;
            rd_q     <= '0;
            etiket_q <= '0;
            ps_q     <= '0;
            eski_q   <= '0;
        end else begin
            durum_q <= durum_d;
            if (kabul) begin
                islem_q  <= uop_islem_i[1:0];
                adres_q  <= uop_adres_i;
                kaynak_q <= kaynak_giris;
                yok_q    <= yok_giris;
                rd_q     <= uop_rd_i;
                etiket_q <= uop_etiket_i;
                ps_q     <= uop_ps_i;
            end
            if (oku_al) eski_q <= csr_veri_i;
        end
    end

endmodule

// File: tb/tb_csr_islem_birimi.sv
// tb_csr_islem_birimi
// Table-driven bench for csr_islem_birimi: each vector is a full op run with
// the CSR valid immediately, followed by hand-written multi-cycle sequences
// (late CSR valid, result back-pressure, flushes, reset mid-op).

module tb_csr_islem_birimi;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        uop_gecerli_i;
    logic        uop_hazir_o;
    logic [2:0]  uop_islem_i;
    logic [11:0] uop_adres_i;
    logic [4:0]  uop_rs1_i;
    logic [31:0] uop_rs1_veri_i;
    logic [4:0]  uop_rd_i;
    logic [4:0]  uop_etiket_i;
    logic [31:0] uop_ps_i;
    logic [11:0] oku_istek_adres_o;
    logic [4:0]  oku_istek_etiket_o;
    logic        oku_istek_etiket_gecerli_o;
    logic [31:0] csr_veri_i;
    logic        csr_gecerli_i;
    logic [31:0] yaz_istek_veri_o;
    logic [11:0] yaz_istek_adres_o;
    logic [4:0]  yaz_istek_etiket_o;
    logic        yaz_istek_gecerli_o;
    logic [31:0] sonuc_veri_o;
    logic [4:0]  sonuc_rd_o;
    logic        sonuc_gecerli_o;
    logic        sonuc_hazir_i;
    logic [31:0] odd_ps_o;
    logic [3:0]  odd_kod_o;
    logic [31:0] odd_bilgi_o;
    logic        odd_gecerli_o;
    logic        bosalt_i;

    always #5 clk_i = ~clk_i;

    csr_islem_birimi dut (
        .clk_i                      (clk_i),
        .rst_i                      (rst_i),
        .uop_gecerli_i              (uop_gecerli_i),
        .uop_hazir_o                (uop_hazir_o),
        .uop_islem_i                (uop_islem_i),
        .uop_adres_i                (uop_adres_i),
        .uop_rs1_i                  (uop_rs1_i),
        .uop_rs1_veri_i             (uop_rs1_veri_i),
        .uop_rd_i                   (uop_rd_i),
        .uop_etiket_i               (uop_etiket_i),
        .uop_ps_i                   (uop_ps_i),
        .oku_istek_adres_o          (oku_istek_adres_o),
        .oku_istek_etiket_o         (oku_istek_etiket_o),
        .oku_istek_etiket_gecerli_o (oku_istek_etiket_gecerli_o),
        .csr_veri_i                 (csr_veri_i),
        .csr_gecerli_i              (csr_gecerli_i),
        .yaz_istek_veri_o           (yaz_istek_veri_o),
        .yaz_istek_adres_o          (yaz_istek_adres_o),
        .yaz_istek_etiket_o         (yaz_istek_etiket_o),
        .yaz_istek_gecerli_o        (yaz_istek_gecerli_o),
        .sonuc_veri_o               (sonuc_veri_o),
        .sonuc_rd_o                 (sonuc_rd_o),
        .sonuc_gecerli_o            (sonuc_gecerli_o),
        .sonuc_hazir_i              (sonuc_hazir_i),
        .odd_ps_o                   (odd_ps_o),
        .odd_kod_o                  (odd_kod_o),
        .odd_bilgi_o                (odd_bilgi_o),
        .odd_gecerli_o              (odd_gecerli_o),
        .bosalt_i                   (bosalt_i)
    );

    typedef struct {
        logic [2:0]  islem;
        logic [11:0] adres;
        logic [4:0]  rs1;
        logic [31:0] rs1Veri;
        logic [31:0] csrVeri;
        logic        yasadisi;
        logic [31:0] yazVeri;
        logic [31:0] sonuc;
    } vektor_t;

    vektor_t vek[12];
    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the
    // first post-accept cycle with all uop inputs scrambled to zero.
    task automatic applyStimulus(input logic [2:0] islem, input logic [11:0] adres,
                                 input logic [4:0] rs1, input logic [31:0] rs1Veri,
                                 input logic [4:0] rd, input logic [4:0] etiket,
                                 input logic [31:0] ps);
        uop_islem_i    = islem;
        uop_adres_i    = adres;
        uop_rs1_i      = rs1;
        uop_rs1_veri_i = rs1Veri;
        uop_rd_i       = rd;
        uop_etiket_i   = etiket;
        uop_ps_i       = ps;
        uop_gecerli_i  = 1'b1;
        #1;
        checkOutput("hazirAtAccept", 32'(uop_hazir_o), 32'd1);
        @(negedge clk_i);
        uop_gecerli_i  = 1'b0;
        uop_islem_i    = '0;
        uop_adres_i    = '0;
        uop_rs1_i      = '0;
        uop_rs1_veri_i = '0;
        uop_rd_i       = '0;
        uop_etiket_i   = '0;
        uop_ps_i       = '0;
    endtask

    // OKU cycle with CSR valid immediately; ends at the negedge entering YAZ.
    task automatic claimNow(input logic [31:0] csrVeri, input logic [11:0] adres, input logic [4:0] etiket);
        csr_veri_i    = csrVeri;
        csr_gecerli_i = 1'b1;
        #1;
        checkOutput("claimPulse", 32'(oku_istek_etiket_gecerli_o), 32'd1);
        checkOutput("okuAdres", 32'(oku_istek_adres_o), 32'(adres));
        checkOutput("okuEtiket", 32'(oku_istek_etiket_o), 32'(etiket));
        checkOutput("noWriteInOku", 32'(yaz_istek_gecerli_o), 32'd0);
        @(negedge clk_i);
        csr_gecerli_i = 1'b0;
        csr_veri_i    = 32'h5A5A_A5A5;
    endtask

    task automatic runVector(input int i);
        vektor_t     v;
        logic [4:0]  rd;
        logic [4:0]  etiket;
        logic [31:0] ps;
        v      = vek[i];
        rd     = 5'(i + 1);
        etiket = 5'(i + 3);
        ps     = 32'h0000_1000 + 32'(i * 4);
        applyStimulus(v.islem, v.adres, v.rs1, v.rs1Veri, rd, etiket, ps);
        if (v.yasadisi) begin
            csr_gecerli_i = 1'b1;
            csr_veri_i    = v.csrVeri;
            #1;
            checkOutput("oddGecerli", 32'(odd_gecerli_o), 32'd1);
            checkOutput("oddKod", 32'(odd_kod_o), 32'd2);
            checkOutput("oddBilgi", odd_bilgi_o, {20'd0, v.adres});
            checkOutput("oddPs", odd_ps_o, ps);
            checkOutput("noClaimIllegal", 32'(oku_istek_etiket_gecerli_o), 32'd0);
            checkOutput("noWriteIllegal", 32'(yaz_istek_gecerli_o), 32'd0);
            @(negedge clk_i);
            #1;
            checkOutput("oddHeld", 32'(odd_gecerli_o), 32'd1);
            checkOutput("noWriteIllegalLater", 32'(yaz_istek_gecerli_o), 32'd0);
            csr_gecerli_i = 1'b0;
            bosalt_i = 1'b1;
            @(negedge clk_i);
            bosalt_i = 1'b0;
            #1;
            checkOutput("oddCleared", 32'(odd_gecerli_o), 32'd0);
            checkOutput("hazirAfterOdd", 32'(uop_hazir_o), 32'd1);
        end else begin
            claimNow(v.csrVeri, v.adres, etiket);
            #1;
            checkOutput("yazGecerli", 32'(yaz_istek_gecerli_o), 32'd1);
            checkOutput("yazVeri", yaz_istek_veri_o, v.yazVeri);
            checkOutput("yazAdres", 32'(yaz_istek_adres_o), 32'(v.adres));
            checkOutput("yazEtiket", 32'(yaz_istek_etiket_o), 32'(etiket));
            checkOutput("noClaimInYaz", 32'(oku_istek_etiket_gecerli_o), 32'd0);
            @(negedge clk_i);
            #1;
            checkOutput("sonucGecerli", 32'(sonuc_gecerli_o), 32'd1);
            checkOutput("sonucVeri", sonuc_veri_o, v.sonuc);
            checkOutput("sonucRd", 32'(sonuc_rd_o), 32'(rd));
            checkOutput("singleWrite", 32'(yaz_istek_gecerli_o), 32'd0);
            sonuc_hazir_i = 1'b1;
            @(negedge clk_i);
            sonuc_hazir_i = 1'b0;
            #1;
            checkOutput("sonucDone", 32'(sonuc_gecerli_o), 32'd0);
            checkOutput("hazirAfterOp", 32'(uop_hazir_o), 32'd1);
        end
    endtask

    initial begin
        //              islem   adres    rs1    rs1Veri        csrVeri        ill   yazVeri        sonuc
        vek[0]  = '{3'b001, 12'h305, 5'd1,  32'h8000_0100, 32'h0000_0000, 1'b0, 32'h8000_0100, 32'h0000_0000};
        vek[1]  = '{3'b110, 12'h300, 5'd8,  32'hFFFF_FFFF, 32'h0000_1800, 1'b0, 32'h0000_1808, 32'h0000_1800};
        vek[2]  = '{3'b011, 12'h300, 5'd5,  32'h0000_0008, 32'h0000_1808, 1'b0, 32'h0000_1800, 32'h0000_1808};
        vek[3]  = '{3'b010, 12'hF14, 5'd0,  32'h0000_DEAD, 32'h0000_0007, 1'b0, 32'h0000_0007, 32'h0000_0007};
        vek[4]  = '{3'b001, 12'hF14, 5'd3,  32'h0000_0001, 32'h0000_0007, 1'b1, 32'h0,         32'h0};
        vek[5]  = '{3'b000, 12'h305, 5'd2,  32'h0000_0001, 32'h0,         1'b1, 32'h0,         32'h0};
        vek[6]  = '{3'b100, 12'h340, 5'd2,  32'h0000_0001, 32'h0,         1'b1, 32'h0,         32'h0};
        vek[7]  = '{3'b111, 12'h344, 5'h1F, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFE0, 32'hFFFF_FFFF};
        vek[8]  = '{3'b101, 12'h340, 5'h15, 32'hCAFE_0000, 32'h0000_1234, 1'b0, 32'h0000_0015, 32'h0000_1234};
        vek[9]  = '{3'b110, 12'hC00, 5'd0,  32'h0000_0000, 32'h0000_ABCD, 1'b0, 32'h0000_ABCD, 32'h0000_ABCD};
        vek[10] = '{3'b111, 12'hC00, 5'd3,  32'h0000_0000, 32'h0000_ABCD, 1'b1, 32'h0,         32'h0};
        vek[11] = '{3'b001, 12'h340, 5'd0,  32'h0000_0000, 32'h0000_1234, 1'b0, 32'h0000_0000, 32'h0000_1234};

        rst_i          = 1'b1;
        uop_gecerli_i  = 1'b1;
        uop_islem_i    = 3'b001;
        uop_adres_i    = 12'h305;
        uop_rs1_i      = 5'd1;
        uop_rs1_veri_i = 32'h1;
        uop_rd_i       = 5'd1;
        uop_etiket_i   = 5'd1;
        uop_ps_i       = 32'h0;
        csr_veri_i     = 32'h0;
        csr_gecerli_i  = 1'b1;
        sonuc_hazir_i  = 1'b0;
        bosalt_i       = 1'b0;

        // Reset: everything low, even with a valid op offered.
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("rstHazir", 32'(uop_hazir_o), 32'd0);
        checkOutput("rstClaim", 32'(oku_istek_etiket_gecerli_o), 32'd0);
        checkOutput("rstYaz", 32'(yaz_istek_gecerli_o), 32'd0);
        checkOutput("rstSonuc", 32'(sonuc_gecerli_o), 32'd0);
        checkOutput("rstOdd", 32'(odd_gecerli_o), 32'd0);
        uop_gecerli_i = 1'b0;
        csr_gecerli_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("hazirAfterReset", 32'(uop_hazir_o), 32'd1);

        for (int i = 0; i < 12; i++) runVector(i);

        // Flush while idle: nothing is accepted that cycle.
        @(negedge clk_i);
        bosalt_i      = 1'b1;
        uop_gecerli_i = 1'b1;
        uop_islem_i   = 3'b001;
        uop_adres_i   = 12'h340;
        #1;
        checkOutput("hazirDuringFlush", 32'(uop_hazir_o), 32'd0);
        @(negedge clk_i);
        bosalt_i      = 1'b0;
        uop_gecerli_i = 1'b0;
        #1;
        checkOutput("idleAfterFlush", 32'(uop_hazir_o), 32'd1);

        // CSR valid late by 3 cycles, then result held for 2 cycles.
        @(negedge clk_i);
        applyStimulus(3'b001, 12'h340, 5'd4, 32'h0000_0011, 5'd9, 5'd7, 32'h2000);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("noClaimWhileInvalid", 32'(oku_istek_etiket_gecerli_o), 32'd0);
            checkOutput("hazirLowInOku", 32'(uop_hazir_o), 32'd0);
            @(negedge clk_i);
        end
        claimNow(32'h0000_0077, 12'h340, 5'd7);
        #1;
        checkOutput("lateYazVeri", yaz_istek_veri_o, 32'h0000_0011);
        @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            #1;
            checkOutput("heldSonucGecerli", 32'(sonuc_gecerli_o), 32'd1);
            checkOutput("heldSonucVeri", sonuc_veri_o, 32'h0000_0077);
            checkOutput("heldSonucRd", 32'(sonuc_rd_o), 32'd9);
            checkOutput("hazirLowInSonuc", 32'(uop_hazir_o), 32'd0);
            @(negedge clk_i);
        end
        sonuc_hazir_i = 1'b1;
        @(negedge clk_i);
        sonuc_hazir_i = 1'b0;
        #1;
        checkOutput("hazirAfterHeld", 32'(uop_hazir_o), 32'd1);

        // Flush in SONUC: result dropped.
        @(negedge clk_i);
        applyStimulus(3'b010, 12'h340, 5'd6, 32'h0000_0100, 5'd2, 5'd2, 32'h3000);
        claimNow(32'h0000_0001, 12'h340, 5'd2);
        @(negedge clk_i);
        bosalt_i = 1'b1;
        #1;
        checkOutput("sonucBeforeFlush", 32'(sonuc_gecerli_o), 32'd1);
        @(negedge clk_i);
        bosalt_i = 1'b0;
        #1;
        checkOutput("sonucDroppedFlush", 32'(sonuc_gecerli_o), 32'd0);
        checkOutput("hazirAfterSonucFlush", 32'(uop_hazir_o), 32'd1);

        // Flush in YAZ: write still issued, no result.
        @(negedge clk_i);
        applyStimulus(3'b010, 12'h340, 5'd6, 32'h0000_0100, 5'd2, 5'd2, 32'h3000);
        claimNow(32'h0000_0001, 12'h340, 5'd2);
        bosalt_i = 1'b1;
        #1;
        checkOutput("yazDuringFlush", 32'(yaz_istek_gecerli_o), 32'd1);
        checkOutput("yazVeriDuringFlush", yaz_istek_veri_o, 32'h0000_0101);
        @(negedge clk_i);
        bosalt_i = 1'b0;
        #1;
        checkOutput("noSonucAfterYazFlush", 32'(sonuc_gecerli_o), 32'd0);
        checkOutput("hazirAfterYazFlush", 32'(uop_hazir_o), 32'd1);

        // Reset in OKU: op dropped with no claim and no write.
        @(negedge clk_i);
        applyStimulus(3'b001, 12'h305, 5'd1, 32'h0000_00FF, 5'd3, 5'd4, 32'h4000);
        rst_i         = 1'b1;
        csr_gecerli_i = 1'b1;
        csr_veri_i    = 32'h1111_2222;
        #1;
        checkOutput("noClaimInReset", 32'(oku_istek_etiket_gecerli_o), 32'd0);
        checkOutput("okuAdresInReset", 32'(oku_istek_adres_o), 32'd0);
        @(negedge clk_i);
        rst_i         = 1'b0;
        csr_gecerli_i = 1'b0;
        #1;
        checkOutput("hazirAfterMidReset", 32'(uop_hazir_o), 32'd1);
        checkOutput("noWriteAfterReset", 32'(yaz_istek_gecerli_o), 32'd0);
        @(negedge clk_i);
        #1;
        checkOutput("noWriteLater", 32'(yaz_istek_gecerli_o), 32'd0);
        checkOutput("noSonucLater", 32'(sonuc_gecerli_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_islem_birimi.md
# csr_islem_birimi

Execute-stage CSR micro-op unit that sits directly upstream of the control/status register unit. It accepts one Zicsr micro-op at a time and claims the CSR with the op's tag while reading the old value. It then issues the read-modify-write back to the CSR unit, returns the old value for `rd`, and raises an illegal-instruction exception on the execute exception port when the op is not legal.

## Interface
- `MXLEN`, 32, data/CSR width
- `CSR_ADRES_BIT`, 12, CSR specification address width
- `UOP_TAG_BIT`, 5, micro-op tag width
- `EXC_CODE_BIT`, 4, exception code width
- `PS_BIT`, 32, program counter width
- `clk_i`  in  1  clock; all state changes on rising edge
- `rst_i`  in  1  synchronous active-high reset
- `uop_gecerli_i`  in  1  micro-op valid
- `uop_hazir_o`  out  1  unit can accept; equals (state==BOSTA) && !bosalt_i && !rst_i
- `uop_islem_i`  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- `uop_adres_i`  in  CSR_ADRES_BIT  CSR address
- `uop_rs1_i`  in  5  rs1 index, or uimm for the I variants
- `uop_rs1_veri_i`  in  MXLEN  rs1 value
- `uop_rd_i`  in  5  destination register
- `uop_etiket_i`  in  UOP_TAG_BIT  op tag
- `uop_ps_i`  in  PS_BIT  op program counter
- `oku_istek_adres_o`  out  CSR_ADRES_BIT  read address (latched op address)
- `oku_istek_etiket_o`  out  UOP_TAG_BIT  claim tag
- `oku_istek_etiket_gecerli_o`  out  1  claim pulse
- `csr_veri_i` / `csr_gecerli_i`  in  MXLEN / 1  combinational read data and CSR-valid flag from the CSR unit
- `yaz_istek_veri_o`, `yaz_istek_adres_o`, `yaz_istek_etiket_o`, `yaz_istek_gecerli_o`  out  MXLEN, CSR_ADRES_BIT, UOP_TAG_BIT, 1  write request
- `sonuc_veri_o`, `sonuc_rd_o`, `sonuc_gecerli_o`  out  MXLEN, 5, 1  result toward writeback
- `sonuc_hazir_i`  in  1  writeback accepts the result
- `odd_ps_o`, `odd_kod_o`, `odd_bilgi_o`, `odd_gecerli_o`  out  PS_BIT, EXC_CODE_BIT, MXLEN, 1  execute exception port
- `bosalt_i`  in  1  pipeline flush from the CSR unit

## Operation
- Accept: when `uop_gecerli_i && uop_hazir_o`, latch all `uop_*` fields.
  - Source value = `uop_rs1_veri_i` when `islem[2]`=0; otherwise the zero-extended 5-bit uimm.
  - Write-suppress flag `yok` = (RS, RC, RSI or RCI) && `uop_rs1_i`==0.
- Illegal op when either condition holds:
  - `islem` is 000 or 100.
  - `adres[11:10]`==2'b11 (read-only CSR) && !yok.
  - Illegal op → state ISTISNA; no CSR request is made.
- States:
  - **BOSTA**: idle. Legal accept → OKU; illegal accept → ISTISNA.
  - **OKU**: drive `oku_istek_adres_o`.
    - If `csr_gecerli_i`=1: capture `csr_veri_i` as `eski`, assert `oku_istek_etiket_gecerli_o` for this cycle only, go to YAZ.
    - If `csr_gecerli_i`=0: stay in OKU with no claim.
  - **YAZ**: `yaz_istek_gecerli_o`=1 for exactly one cycle, with the latched address and tag.
    - Data: RW → src; RS → eski|src; RC → eski&~src; `yok` → eski unchanged.
    - The write is always issued so the claimed CSR revalidates.
    - Next state SONUC, or BOSTA if `bosalt_i`.
  - **SONUC**: `sonuc_gecerli_o`=1, `sonuc_veri_o`=eski, `sonuc_rd_o`=latched rd (rd=0 is still issued). `sonuc_hazir_i` → BOSTA.
  - **ISTISNA**: `odd_gecerli_o`=1, `odd_kod_o`=2 (illegal instruction), `odd_ps_o`=latched ps, `odd_bilgi_o`=zero-extended address. Held until `bosalt_i` → BOSTA.
- Flush (`bosalt_i`):
  - In OKU or SONUC: abandon the op and go to BOSTA next cycle. No claim is outstanding in OKU.
  - In YAZ: the write still issues.
  - In BOSTA: nothing is accepted that cycle.

## Timing
- Reset (`rst_i` high at an edge): state BOSTA, latched fields and `eski` cleared.
  - All outputs are 0 while `rst_i` is high, including `uop_hazir_o`.
  - `uop_hazir_o`=1 in the first cycle after reset is released.
- Reset mid-op drops the op with no write; the CSR unit is reset in the same cycle.
- Latency with the CSR valid: accept at T, claim at T+1, write at T+2, result at T+3. Minimum 4 cycles per op.
- Each cycle of `csr_gecerli_i`=0 adds one cycle in OKU.
- `sonuc_gecerli_o` and `odd_gecerli_o` stay stable until consumed; the data outputs do not change while their valid is high.
- The claim and the read-data capture happen in the same cycle. At most one claim and one write per op.

## Test plan
- Reset, then RW on 0x305 (mtvec) with rs1 data 0x8000_0100 and CSR holding 0x0: claim at T+1, write 0x8000_0100 at T+2, result 0x0 at T+3.
- RSI on 0x300 with uimm=8 and CSR=0x1800: write 0x1808, result 0x1800. Then RC with rs1=x5 data 0x8 on CSR 0x1808: write 0x1800.
- RS on 0xF14 with rs1=x0: no exception, write of the old value issued, result = old value. RW on 0xF14: `odd_gecerli_o`=1, code 2, `odd_bilgi_o`=0xF14, held until `bosalt_i`, and no read or write request is made.
- `csr_gecerli_i` held low for 3 cycles in OKU: no claim during those cycles; the claim comes in the 4th cycle and the result arrives 3 cycles late.
- `sonuc_hazir_i` low for 2 cycles: result held stable and `uop_hazir_o`=0. Flush in SONUC: result dropped, BOSTA next cycle.
- Flush asserted during YAZ: write still issued that cycle, no result, `uop_hazir_o`=1 next cycle. Reset asserted in OKU: BOSTA with no request.
